// File: rtl/control_pipe.sv
// control_pipe: RV32I decode/control unit with a STAGES-deep registered
// pipeline, valid/ready handshaking, flush, and a saturating counter of
// retired illegal instructions.
module control_pipe #(
  parameter int AWIDTH = 32,
  parameter int STAGES = 1,
  parameter int ICNT_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [31:0]       insn_i,
  input  logic [AWIDTH-1:0] pc_i,
  input  logic              flush_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [AWIDTH-1:0] pc_o,
  output logic [31:0]       insn_o,
  output logic [4:0]        rd_o,
  output logic [4:0]        rs1_o,
  output logic [4:0]        rs2_o,
  output logic              pcsel_o,
  output logic              immsel_o,
  output logic              regwren_o,
  output logic              rs1sel_o,
  output logic              rs2sel_o,
  output logic              memren_o,
  output logic              memwren_o,
  output logic [1:0]        wbsel_o,
  output logic [3:0]        alusel_o,
  output logic              illegal_o,
  output logic [ICNT_W-1:0] illcnt_o
);

  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $fatal(1, "control_pipe: STAGES must be in 1..4");
  end

  // ALU operation codes
  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_LUI   = 4'd10;
  localparam logic [3:0] ALU_AUIPC = 4'd11;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic [AWIDTH-1:0] pc;
    logic [31:0]       insn;
    logic              pcsel;
    logic              immsel;
    logic              regwren;
    logic              rs1sel;
    logic              rs2sel;
    logic              memren;
    logic              memwren;
    logic [1:0]        wbsel;
    logic [3:0]        alusel;
    logic              illegal;
  } ctl_t;

  ctl_t              dec;
  ctl_t              pipe_q [STAGES];
  ctl_t              out_m;
  logic [STAGES-1:0] stage_vld;
  logic [STAGES-1:0] vld_nxt;
  logic [STAGES:0]   vld_src;
  logic [STAGES-1:0] ld;
  logic [3:0]        alu_f3;

  // funct3 -> ALU op; insn[30] picks SUB/SRA, gated per opcode below
  always_comb begin
    alu_f3 = ALU_ADD;
    unique case (insn_i[14:12])
      3'b000: alu_f3 = ALU_ADD;
      3'b001: alu_f3 = ALU_SLL;
      3'b010: alu_f3 = ALU_SLT;
      3'b011: alu_f3 = ALU_SLTU;
      3'b100: alu_f3 = ALU_XOR;
      3'b101: alu_f3 = insn_i[30] ? ALU_SRA : ALU_SRL;
      3'b110: alu_f3 = ALU_OR;
      3'b111: alu_f3 = ALU_AND;
      default: alu_f3 = ALU_ADD;
    endcase
  end

  // Combinational decode of the incoming instruction word
  always_comb begin
    dec         = '0;
    dec.pc      = pc_i;
    dec.insn    = insn_i;
    dec.wbsel   = WB_ALU;
    dec.alusel  = ALU_ADD;
    case (insn_i[6:0])
      OP_R: begin
        dec.regwren = 1'b1;
        dec.alusel  = (insn_i[14:12] == 3'b000 && insn_i[30]) ? ALU_SUB : alu_f3;
      end
      OP_I: begin
        {dec.immsel, dec.regwren, dec.rs2sel} = 3'b111;
        // ADDI has no subtract form; insn[30] only matters for SRAI
        dec.alusel = alu_f3;
      end
      OP_LOAD: begin
        {dec.immsel, dec.regwren, dec.rs2sel, dec.memren} = 4'b1111;
        dec.wbsel = WB_MEM;
      end
      OP_STORE: begin
        {dec.immsel, dec.rs2sel, dec.memwren} = 3'b111;
      end
      OP_BRANCH: begin
        dec.immsel = 1'b1;
        dec.alusel = ALU_SUB;
      end
      OP_JAL: begin
        {dec.pcsel, dec.immsel, dec.regwren, dec.rs1sel, dec.rs2sel} = 5'b11111;
        dec.wbsel = WB_PC4;
      end
      OP_JALR: begin
        {dec.pcsel, dec.immsel, dec.regwren, dec.rs2sel} = 4'b1111;
        dec.wbsel = WB_PC4;
      end
      OP_LUI: begin
        {dec.immsel, dec.regwren, dec.rs1sel, dec.rs2sel} = 4'b1111;
        dec.alusel = ALU_LUI;
      end
      OP_AUIPC: begin
        {dec.immsel, dec.regwren, dec.rs1sel, dec.rs2sel} = 4'b1111;
        dec.alusel = ALU_AUIPC;
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  // A stage may load when it or any stage downstream has a hole, or the
  // consumer takes the output; this collapses bubbles under a stall
  always_comb begin
    logic hole;
    hole = ready_i;
    ld   = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      hole  = hole || !stage_vld[k];
      ld[k] = hole;
    end
  end

  assign ready_o = ld[0];
  assign vld_src = {stage_vld, valid_i};

  // Next valid bit per stage: take upstream valid on load, else hold
  always_comb begin
    vld_nxt = stage_vld;
    for (int k = 0; k < STAGES; k++)
      if (ld[k]) vld_nxt[k] = vld_src[k];
  end

  // Valid bits: reset and flush clear the whole pipe, flush beats accept
  always_ff @(posedge clk) begin
    if (!reset_n)     stage_vld <= '0;
    else if (flush_i) stage_vld <= '0;
    else              stage_vld <= vld_nxt;
  end

  // Payload registers, not reset; outputs are masked while invalid
  always_ff @(posedge clk) begin
    for (int k = 0; k < STAGES; k++)
      if (ld[k]) pipe_q[k] <= (k == 0) ? dec : pipe_q[(k == 0) ? 0 : k - 1];
  end

  assign valid_o = stage_vld[STAGES-1];
  assign out_m   = valid_o ? pipe_q[STAGES-1] : '0;

  // Saturating count of illegal instructions handed downstream
  always_ff @(posedge clk) begin
    if (!reset_n)
      illcnt_o <= '0;
    else if (valid_o && ready_i && out_m.illegal && (illcnt_o != {ICNT_W{1'b1}}))
      illcnt_o <= illcnt_o + 1'b1;
  end

  assign pc_o      = out_m.pc;
  assign insn_o    = out_m.insn;
  assign rd_o      = out_m.insn[11:7];
  assign rs1_o     = out_m.insn[19:15];
  assign rs2_o     = out_m.insn[24:20];
  assign pcsel_o   = out_m.pcsel;
  assign immsel_o  = out_m.immsel;
  assign regwren_o = out_m.regwren;
  assign rs1sel_o  = out_m.rs1sel;
  assign rs2sel_o  = out_m.rs2sel;
  assign memren_o  = out_m.memren;
  assign memwren_o = out_m.memwren;
  assign wbsel_o   = out_m.wbsel;
  assign alusel_o  = out_m.alusel;
  assign illegal_o = out_m.illegal;

endmodule

// File: tb/tb_control_pipe.sv
// Bench for control_pipe: scoreboard of decoded bundles pushed on accept and
// checked as they reach the output, plus per-scenario timing checks.
module tb_control_pipe;
  localparam int ST = 3;
  localparam int CW = 2;
  localparam int CMAX = (1 << CW) - 1;

  localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_SLL = 4'd2, A_SLT = 4'd3,
                         A_SLTU = 4'd4, A_XOR = 4'd5, A_SRL = 4'd6, A_SRA = 4'd7,
                         A_OR = 4'd8, A_AND = 4'd9, A_LUI = 4'd10, A_AUIPC = 4'd11;

  localparam logic [31:0] I_ADDI = 32'h00500093;
  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_SUB  = 32'h402081B3;
  localparam logic [31:0] I_LW   = 32'h0000A283;
  localparam logic [31:0] I_ILL  = 32'hFFFFFFFF;

  logic        clk, reset_n, valid_i, ready_o, flush_i, valid_o, ready_i;
  logic [31:0] insn_i, pc_i, pc_o, insn_o;
  logic [4:0]  rd_o, rs1_o, rs2_o;
  logic        pcsel_o, immsel_o, regwren_o, rs1sel_o, rs2sel_o, memren_o, memwren_o, illegal_o;
  logic [1:0]  wbsel_o;
  logic [3:0]  alusel_o;
  logic [CW-1:0] illcnt_o;
  logic [13:0] ctl_o;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] insn;
    logic [13:0] ctl;
  } exp_t;

  exp_t sb[$];
  int total = 0, bad = 0, exp_cnt = 0, retired = 0;
  logic [31:0] pc_next = 32'h1000;

  control_pipe #(.AWIDTH(32), .STAGES(ST), .ICNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .valid_i(valid_i), .ready_o(ready_o),
    .insn_i(insn_i), .pc_i(pc_i), .flush_i(flush_i), .valid_o(valid_o),
    .ready_i(ready_i), .pc_o(pc_o), .insn_o(insn_o), .rd_o(rd_o), .rs1_o(rs1_o),
    .rs2_o(rs2_o), .pcsel_o(pcsel_o), .immsel_o(immsel_o), .regwren_o(regwren_o),
    .rs1sel_o(rs1sel_o), .rs2sel_o(rs2sel_o), .memren_o(memren_o),
    .memwren_o(memwren_o), .wbsel_o(wbsel_o), .alusel_o(alusel_o),
    .illegal_o(illegal_o), .illcnt_o(illcnt_o)
  );

  assign ctl_o = {pcsel_o, immsel_o, regwren_o, rs1sel_o, rs2sel_o, memren_o, memwren_o,
                  wbsel_o, alusel_o, illegal_o};

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Reference decode: {pcsel,immsel,regwren,rs1sel,rs2sel,memren,memwren,wbsel,alusel,illegal}
  function automatic logic [13:0] model(input logic [31:0] w);
    logic [3:0] a;
    case (w[14:12])
      3'd0: a = A_ADD;  3'd1: a = A_SLL;  3'd2: a = A_SLT;  3'd3: a = A_SLTU;
      3'd4: a = A_XOR;  3'd5: a = w[30] ? A_SRA : A_SRL;
      3'd6: a = A_OR;   default: a = A_AND;
    endcase
    case (w[6:0])
      7'b0110011: return {7'b0010000, 2'b00, (w[14:12] == 3'd0 && w[30]) ? A_SUB : a, 1'b0};
      7'b0010011: return {7'b0110100, 2'b00, a, 1'b0};
      7'b0000011: return {7'b0110110, 2'b01, A_ADD, 1'b0};
      7'b0100011: return {7'b0100101, 2'b00, A_ADD, 1'b0};
      7'b1100011: return {7'b0100000, 2'b00, A_SUB, 1'b0};
      7'b1101111: return {7'b1111100, 2'b10, A_ADD, 1'b0};
      7'b1100111: return {7'b1110100, 2'b10, A_ADD, 1'b0};
      7'b0110111: return {7'b0111100, 2'b00, A_LUI, 1'b0};
      7'b0010111: return {7'b0111100, 2'b00, A_AUIPC, 1'b0};
      default:    return {7'b0000000, 2'b00, A_ADD, 1'b1};
    endcase
  endfunction

  // Scoreboard: compare output to head, pop on retire, push on accept
  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      sb.delete();
      exp_cnt = 0;
    end else begin
      total++;
      if (illcnt_o !== CW'(exp_cnt)) begin
        bad++;
        $display("FAIL illcnt: got %0d want %0d", illcnt_o, exp_cnt);
      end
      total++;
      if (valid_o) begin
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_out: got pc=%h insn=%h want no output", pc_o, insn_o);
        end else begin
          e = sb[0];
          if ({pc_o, insn_o, rd_o, rs1_o, rs2_o, ctl_o} !==
              {e.pc, e.insn, e.insn[11:7], e.insn[19:15], e.insn[24:20], e.ctl}) begin
            bad++;
            $display("FAIL out_bundle: got pc=%h insn=%h ctl=%b want pc=%h insn=%h ctl=%b",
                     pc_o, insn_o, ctl_o, e.pc, e.insn, e.ctl);
          end
          if (ready_i) begin
            void'(sb.pop_front());
            retired++;
            if (e.ctl[0] && exp_cnt < CMAX) exp_cnt++;
          end
        end
      end else if ({pc_o, insn_o, rd_o, rs1_o, rs2_o, ctl_o} !== 83'd0) begin
        bad++;
        $display("FAIL idle_zero: got pc=%h insn=%h ctl=%b want all zero", pc_o, insn_o, ctl_o);
      end
      if (flush_i) sb.delete();
      else if (valid_i && ready_o) sb.push_back('{pc_i, insn_i, model(insn_i)});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction and hold it until accepted
  task automatic send(input logic [31:0] w);
    int n = 0;
    valid_i = 1; insn_i = w; pc_i = pc_next;
    @(negedge clk);
    while (!ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ready_o) begin
      total++; bad++;
      $display("FAIL send_timeout: got ready_o=0 want 1 within 50 cycles");
    end
    tick();
    valid_i = 0;
    pc_next += 4;
  endtask

  task automatic drain();
    int n = 0;
    ready_i = 1; valid_i = 0; flush_i = 0;
    while ((sb.size() != 0 || valid_o) && n < 100) begin
      tick();
      n++;
    end
    total++;
    if (sb.size() != 0 || valid_o) begin
      bad++;
      $display("FAIL drain: got pending=%0d valid_o=%b want 0 0", sb.size(), valid_o);
    end
  endtask

  task automatic test_reset();
    reset_n = 0; valid_i = 0; flush_i = 0; ready_i = 1; insn_i = 0; pc_i = 0;
    repeat (3) tick();
    @(negedge clk);
    total++;
    if ({valid_o, illcnt_o, pc_o, insn_o, ctl_o} !== '0) begin
      bad++;
      $display("FAIL reset_state: got valid=%b cnt=%0d pc=%h ctl=%b want zeros",
               valid_o, illcnt_o, pc_o, ctl_o);
    end
    tick();
    reset_n = 1;
    @(negedge clk);
    total++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: got ready=%b valid=%b want 1 0", ready_o, valid_o);
    end
    tick();
  endtask

  task automatic test_addi();
    ready_i = 1;
    send(I_ADDI);
    for (int i = 0; i < ST - 1; i++) begin
      @(negedge clk);
      total++;
      if (valid_o !== 1'b0) begin
        bad++;
        $display("FAIL addi_early: got valid_o=1 want 0 at wait %0d", i);
      end
      tick();
    end
    @(negedge clk);
    total++;
    if ({valid_o, rd_o, immsel_o, rs2sel_o, regwren_o, alusel_o} !== {1'b1, 5'd1, 3'b111, A_ADD}) begin
      bad++;
      $display("FAIL addi_latency: got valid=%b rd=%0d imm=%b rs2=%b wr=%b alu=%0d want 1 1 1 1 1 0",
               valid_o, rd_o, immsel_o, rs2sel_o, regwren_o, alusel_o);
    end
    tick();
    drain();
  endtask

  task automatic test_back_to_back();
    ready_i = 1;
    send(I_ADD);
    send(I_SUB);
    for (int i = 0; i < ST - 2; i++) tick();
    @(negedge clk);
    total++;
    if ({valid_o, alusel_o, insn_o} !== {1'b1, A_ADD, I_ADD}) begin
      bad++;
      $display("FAIL b2b_first: got valid=%b alu=%0d insn=%h want 1 0 %h", valid_o, alusel_o, insn_o, I_ADD);
    end
    tick();
    @(negedge clk);
    total++;
    if ({valid_o, alusel_o, insn_o} !== {1'b1, A_SUB, I_SUB}) begin
      bad++;
      $display("FAIL b2b_second: got valid=%b alu=%0d insn=%h want 1 1 %h", valid_o, alusel_o, insn_o, I_SUB);
    end
    tick();
    drain();
  endtask

  task automatic test_stall();
    int acc = 0, r0;
    logic was;
    ready_i = 0;
    r0 = retired;
    for (int c = 0; c < 5; c++) begin
      valid_i = 1;
      insn_i = I_ADDI | (32'(acc + 2) << 7);
      pc_i = pc_next;
      @(negedge clk);
      total++;
      if (ready_o !== (acc < ST)) begin
        bad++;
        $display("FAIL stall_ready: got %b want %b after %0d accepts", ready_o, acc < ST, acc);
      end
      was = ready_o;
      tick();
      if (was) begin
        acc++;
        pc_next += 4;
      end
    end
    valid_i = 0;
    drain();
    total++;
    if (retired - r0 !== ST) begin
      bad++;
      $display("FAIL stall_count: got %0d retired want %0d", retired - r0, ST);
    end
  endtask

  task automatic test_flush();
    ready_i = 1;
    repeat (ST) send(I_ADD);
    valid_i = 1; insn_i = I_LW; pc_i = pc_next; flush_i = 1;
    tick();
    flush_i = 0; valid_i = 0;
    @(negedge clk);
    total++;
    if (valid_o !== 1'b0) begin
      bad++;
      $display("FAIL flush_valid: got valid_o=%b want 0", valid_o);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      @(negedge clk);
      total++;
      if (valid_o && insn_o == I_LW) begin
        bad++;
        $display("FAIL flush_leak: got LW at output want none");
      end
    end
    drain();
  endtask

  task automatic test_random_mix();
    logic [6:0] ops [10] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                             7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1111111};
    logic [31:0] w;
    for (int i = 0; i < 120; i++) begin
      w = $urandom;
      w[6:0] = ops[$urandom_range(0, 9)];
      valid_i = ($urandom_range(0, 3) != 0);
      ready_i = ($urandom_range(0, 3) != 0);
      flush_i = ($urandom_range(0, 40) == 0);
      insn_i = w; pc_i = pc_next;
      pc_next += 4;
      tick();
    end
    drain();
  endtask

  task automatic test_illegal();
    reset_n = 0;
    tick();
    reset_n = 1;
    ready_i = 1;
    fork
      repeat (6) send(I_ILL);
      begin
        int k = 0, n = 0;
        while (k < 6 && n < 60) begin
          @(negedge clk);
          if (valid_o) begin
            total++;
            if ({illegal_o, regwren_o, memwren_o, illcnt_o} !== {3'b100, CW'(k < CMAX ? k : CMAX)}) begin
              bad++;
              $display("FAIL illegal_retire: got ill=%b wr=%b mw=%b cnt=%0d want 1 0 0 %0d",
                       illegal_o, regwren_o, memwren_o, illcnt_o, k < CMAX ? k : CMAX);
            end
            k++;
          end
          n++;
        end
        total++;
        if (k < 6) begin
          bad++;
          $display("FAIL illegal_timeout: got %0d outputs want 6", k);
        end
      end
    join
    tick();
    @(negedge clk);
    total++;
    if (illcnt_o !== CW'(CMAX)) begin
      bad++;
      $display("FAIL illcnt_sat: got %0d want %0d", illcnt_o, CMAX);
    end
    drain();
  endtask

  task automatic test_reset_midstream();
    ready_i = 0;
    send(I_ADD);
    send(I_SUB);
    reset_n = 0;
    tick();
    @(negedge clk);
    total++;
    if (valid_o !== 1'b0 || illcnt_o !== '0) begin
      bad++;
      $display("FAIL midreset: got valid=%b cnt=%0d want 0 0", valid_o, illcnt_o);
    end
    tick();
    reset_n = 1;
    @(negedge clk);
    total++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
      bad++;
      $display("FAIL midreset_release: got ready=%b valid=%b want 1 0", ready_o, valid_o);
    end
    tick();
    drain();
  endtask

  initial begin
    reset_n = 0; valid_i = 0; flush_i = 0; ready_i = 1; insn_i = 0; pc_i = 0;
    test_reset();
    test_addi();
    test_back_to_back();
    test_stall();
    test_flush();
    test_random_mix();
    test_illegal();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
